// File: rtl/mem_io_pkg.sv
// Shared encodings for the memory-side bridge: bus commands, I/O addresses, decode selects.
// Pure definitions, no logic; latency and backpressure are not applicable.
package mem_io_pkg;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    localparam logic [8:0] ADDR_LED    = 9'h100;
    localparam logic [8:0] ADDR_SW     = 9'h140;
    localparam logic [8:0] ADDR_TCOUNT = 9'h180;
    localparam logic [8:0] ADDR_TCMP   = 9'h181;
    localparam logic [8:0] ADDR_TSTAT  = 9'h182;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_SW,
        SEL_TCNT,
        SEL_TCMP,
        SEL_TSTAT,
        SEL_NONE
    } sel_e;

    // Timer selects are always decoded; a build without the timer simply never acts on them.
    function automatic sel_e addr_decode(input logic [8:0] addr);
        sel_e sel;
        if (!addr[8])                 sel = SEL_RAM;
        else if (addr == ADDR_LED)    sel = SEL_LED;
        else if (addr == ADDR_SW)     sel = SEL_SW;
        else if (addr == ADDR_TCOUNT) sel = SEL_TCNT;
        else if (addr == ADDR_TCMP)   sel = SEL_TCMP;
        else if (addr == ADDR_TSTAT)  sel = SEL_TSTAT;
        else                          sel = SEL_NONE;
        return sel;
    endfunction

endpackage

// File: rtl/io_timer.sv
// Prescaled 16-bit up-counter with compare register and sticky match flag.
// Loads/clears land on the ending edge; no backpressure (always accepts strobes).
module io_timer #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_load,
    input  logic        cmp_load,
    input  logic        stat_clr,
    input  logic [15:0] load_data,
    output logic [15:0] tcount,
    output logic [15:0] tcmp,
    output logic        tstat
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;
    logic [15:0]   tcount_inc;
    logic          wrap;
    logic          match;

    assign wrap       = (pcnt == PW'(PRESCALE - 1));
    assign tcount_inc = tcount + 16'd1;
    // A CPU load of TCOUNT pre-empts the increment, so it also pre-empts the match.
    assign match      = wrap && !cnt_load && (tcount_inc == tcmp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt   <= '0;
            tcount <= '0;
        end else if (cnt_load) begin
            pcnt   <= '0;
            tcount <= load_data;
        end else if (wrap) begin
            pcnt   <= '0;
            tcount <= tcount_inc;
        end else begin
            pcnt   <= pcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcmp  <= 16'hFFFF;
            tstat <= 1'b0;
        end else begin
            if (cmp_load)
                tcmp <= load_data;
            if (match)
                tstat <= 1'b1;
            else if (stat_clr)
                tstat <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_io_bridge.sv
// CPU memory bridge: RAM pass-through, LED reg, synchronised switches, optional timer (MEM_IO_TIMER_EN).
// Reads combinational (0 cycles), writes on the ending edge; no backpressure, CPU holds each command.
module mem_io_bridge
    import mem_io_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_cmd,
    input  logic [8:0]  mem_addr,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_din,
    output logic        ram_we,
    input  logic [15:0] ram_dout,
    input  logic [7:0]  sw,
    output logic [7:0]  led,
    output logic        timer_irq
);

    sel_e       sel;
    logic       is_rd;
    logic       is_wr;
    logic [7:0] sw_sync1;
    logic [7:0] sw_sync2;

    assign sel   = addr_decode(mem_addr);
    assign is_rd = (mem_cmd == MREAD);
    assign is_wr = (mem_cmd == MWRITE);

    assign ram_addr = mem_addr[7:0];
    assign ram_din  = write_data;
    assign ram_we   = reset && is_wr && (sel == SEL_RAM);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            led <= '0;
        else if (is_wr && sel == SEL_LED)
            led <= write_data[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_sync1 <= '0;
            sw_sync2 <= '0;
        end else begin
            sw_sync1 <= sw;
            sw_sync2 <= sw_sync1;
        end
    end

`ifdef MEM_IO_TIMER_EN
    logic [15:0] tcount;
    logic [15:0] tcmp;
    logic        tstat;

    io_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .cnt_load  (is_wr && sel == SEL_TCNT),
        .cmp_load  (is_wr && sel == SEL_TCMP),
        .stat_clr  (is_wr && sel == SEL_TSTAT && write_data[0]),
        .load_data (write_data),
        .tcount    (tcount),
        .tcmp      (tcmp),
        .tstat     (tstat)
    );

    assign timer_irq = tstat;
`else
    logic [31:0] unused_prescale;

    assign unused_prescale = 32'(PRESCALE);
    assign timer_irq       = 1'b0;
`endif

    always_comb begin
        read_data = '0;
        if (is_rd) begin
            case (sel)
                SEL_RAM:   read_data = ram_dout;
                SEL_LED:   read_data = {8'h00, led};
                SEL_SW:    read_data = {8'h00, sw_sync2};
`ifdef MEM_IO_TIMER_EN
                SEL_TCNT:  read_data = tcount;
                SEL_TCMP:  read_data = tcmp;
                SEL_TSTAT: read_data = {15'b0, tstat};
`endif
                default:   read_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge with a cycle-level reference model and per-cycle compare.
module tb_mem_io_bridge;

    localparam int PRE = 2;

    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [1:0]  mem_cmd    = 2'b00;
    logic [8:0]  mem_addr   = 9'h000;
    logic [15:0] write_data = 16'h0000;
    logic [15:0] ram_dout   = 16'h0000;
    logic [7:0]  sw         = 8'h00;
    logic [15:0] read_data;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_we;
    logic [7:0]  led;
    logic        timer_irq;

    int checks = 0;
    int errors = 0;

    mem_io_bridge #(.PRESCALE(PRE)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_we     (ram_we),
        .ram_dout   (ram_dout),
        .sw         (sw),
        .led        (led),
        .timer_irq  (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: timer value derived from load value plus elapsed edges / PRE.
    logic [7:0]  m_led   = 8'h00;
    logic [7:0]  m_sw1   = 8'h00;
    logic [7:0]  m_sw2   = 8'h00;
    logic [15:0] m_base  = 16'h0000;
    logic [15:0] m_tcmp  = 16'hFFFF;
    int          m_elapsed = 0;
    logic        m_flag  = 1'b0;
    logic        m_wr;

    assign m_wr = (mem_cmd == 2'b10);

    function automatic logic [15:0] tc_at(input logic [15:0] b, input int el);
        return b + 16'(el / PRE);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_led     <= 8'h00;
            m_sw1     <= 8'h00;
            m_sw2     <= 8'h00;
            m_base    <= 16'h0000;
            m_tcmp    <= 16'hFFFF;
            m_elapsed <= 0;
            m_flag    <= 1'b0;
        end else begin
            m_sw1 <= sw;
            m_sw2 <= m_sw1;
            if (m_wr && mem_addr == 9'h100)
                m_led <= write_data[7:0];
`ifdef MEM_IO_TIMER_EN
            if (m_wr && mem_addr == 9'h180) begin
                m_base    <= write_data;
                m_elapsed <= 0;
            end else begin
                m_elapsed <= m_elapsed + 1;
            end
            if (m_wr && mem_addr == 9'h181)
                m_tcmp <= write_data;
            if (!(m_wr && mem_addr == 9'h180) && ((m_elapsed + 1) % PRE == 0)
                && tc_at(m_base, m_elapsed + 1) == m_tcmp)
                m_flag <= 1'b1;
            else if (m_wr && mem_addr == 9'h182 && write_data[0])
                m_flag <= 1'b0;
`endif
        end
    end

    function automatic logic [15:0] exp_rd();
        if (mem_cmd != 2'b01) return 16'h0000;
        if (!mem_addr[8])     return ram_dout;
        case (mem_addr)
            9'h100: return {8'h00, m_led};
            9'h140: return {8'h00, m_sw2};
`ifdef MEM_IO_TIMER_EN
            9'h180: return tc_at(m_base, m_elapsed);
            9'h181: return m_tcmp;
            9'h182: return {15'b0, m_flag};
`endif
            default: return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_led", led, 0);
            chk("rst_irq", timer_irq, 0);
            chk("rst_ram_we", ram_we, 0);
        end else begin
            chk("cyc_read_data", read_data, exp_rd());
            chk("cyc_ram_we", ram_we, (mem_cmd == 2'b10) && !mem_addr[8]);
            chk("cyc_ram_addr", ram_addr, mem_addr[7:0]);
            chk("cyc_ram_din", ram_din, write_data);
            chk("cyc_led", led, m_led);
            chk("cyc_irq", timer_irq, m_flag);
        end
    end

    task automatic drive(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
        mem_cmd    = c;
        mem_addr   = a;
        write_data = d;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        mem_cmd = 2'b00;
        reset   = 1'b0;
        step();
        step();
        reset   = 1'b1;
    endtask

    initial begin
        // WRITE held during reset must not reach the RAM
        reset = 1'b0; mem_cmd = 2'b10; mem_addr = 9'h005; write_data = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ram_we_hold", ram_we, 0);
        reset = 1'b1;

        drive(2'b10, 9'h005, 16'h1234);
        chk("ram_we_wr", ram_we, 1);
        chk("ram_addr_wr", ram_addr, 8'h05);
        chk("ram_din_wr", ram_din, 16'h1234);
        step();
        ram_dout = 16'h1234;
        drive(2'b01, 9'h005, 16'h0000);
        chk("ram_rd", read_data, 16'h1234);
        step();
        drive(2'b10, 9'h105, 16'h5555);
        chk("ram_we_io", ram_we, 0);
        step();

        drive(2'b10, 9'h100, 16'hABCD);
        step();
        chk("led_wr", led, 8'hCD);
        drive(2'b01, 9'h100, 16'h0000);
        chk("led_rd", read_data, 16'h00CD);
        step();

        sw = 8'h5A;
        drive(2'b01, 9'h140, 16'h0000);
        chk("sw_edge0", read_data, 16'h0000);
        step();
        drive(2'b01, 9'h140, 16'h0000);
        chk("sw_edge1", read_data, 16'h0000);
        step();
        drive(2'b01, 9'h140, 16'h0000);
        chk("sw_edge2", read_data, 16'h005A);
        step();
        drive(2'b10, 9'h140, 16'hFFFF);
        step();
        drive(2'b01, 9'h140, 16'h0000);
        chk("sw_wr_ignored", read_data, 16'h005A);
        step();

        drive(2'b01, 9'h1FF, 16'h0000);
        chk("unmapped_rd", read_data, 16'h0000);
        step();
        drive(2'b10, 9'h1FF, 16'hFFFF);
        step();
        drive(2'b11, 9'h100, 16'h0011);
        chk("cmd11_rd", read_data, 16'h0000);
        step();
        chk("cmd11_led", led, 8'hCD);

`ifndef MEM_IO_TIMER_EN
        drive(2'b10, 9'h181, 16'h0003);
        step();
        drive(2'b10, 9'h180, 16'h0002);
        step();
        drive(2'b01, 9'h180, 16'h0000);
        chk("toff_tcount", read_data, 16'h0000);
        step();
        drive(2'b01, 9'h181, 16'h0000);
        chk("toff_tcmp", read_data, 16'h0000);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(2'b00, 9'h000, 16'h0000);
            step();
        end
        chk("toff_irq", timer_irq, 0);
`endif

        // asynchronous reset mid-run
        reset = 1'b0;
        #1;
        chk("arst_led", led, 0);
        chk("arst_irq", timer_irq, 0);
        step();
        step();
        reset = 1'b1;
        drive(2'b01, 9'h181, 16'h0000);
`ifdef MEM_IO_TIMER_EN
        chk("rst_tcmp", read_data, 16'hFFFF);
`else
        chk("rst_tcmp", read_data, 16'h0000);
`endif
        step();
        drive(2'b01, 9'h180, 16'h0000);
        chk("rst_tcount", read_data, 16'h0000);
        step();

`ifdef MEM_IO_TIMER_EN
        // TCMP=3, PRESCALE=2: match at the 6th edge, coinciding with a clear write
        pulse_reset();
        drive(2'b10, 9'h181, 16'h0003);
        step();
        for (int i = 2; i <= 5; i++) begin
            drive(2'b00, 9'h000, 16'h0000);
            chk("irq_before_match", timer_irq, 0);
            step();
        end
        drive(2'b10, 9'h182, 16'h0001);
        chk("irq_before_match", timer_irq, 0);
        step();
        chk("irq_rise_set_wins", timer_irq, 1);
        drive(2'b01, 9'h182, 16'h0000);
        chk("tstat_rd_set", read_data, 16'h0001);
        step();
        drive(2'b10, 9'h182, 16'h0001);
        step();
        chk("irq_cleared", timer_irq, 0);
        drive(2'b01, 9'h182, 16'h0000);
        chk("tstat_rd_clr", read_data, 16'h0000);
        step();

        // TCOUNT load on a prescale-wrap cycle
        pulse_reset();
        drive(2'b00, 9'h000, 16'h0000);
        step();
        drive(2'b10, 9'h180, 16'h0010);
        step();
        drive(2'b01, 9'h180, 16'h0000);
        chk("tcnt_load_wins", read_data, 16'h0010);
        step();
        drive(2'b01, 9'h180, 16'h0000);
        chk("tcnt_hold", read_data, 16'h0010);
        step();
        drive(2'b01, 9'h180, 16'h0000);
        chk("tcnt_inc", read_data, 16'h0011);
        step();
        drive(2'b10, 9'h181, 16'h0011);
        step();
        chk("tcmp_wr_no_match", timer_irq, 0);
`endif

        drive(2'b00, 9'h000, 16'h0000);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
